// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU op bit indices, op-class masks,
// and the execute-stage state encoding.
package cpu_pkg;

  localparam int ALU_OP_W = 19;

  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_SLT  = 2;
  localparam int OP_SLTU = 3;
  localparam int OP_AND  = 4;
  localparam int OP_NOR  = 5;
  localparam int OP_OR   = 6;
  localparam int OP_XOR  = 7;
  localparam int OP_SLL  = 8;
  localparam int OP_SRL  = 9;
  localparam int OP_SRA  = 10;
  localparam int OP_LUI  = 11;
  localparam int OP_MUL  = 12;
  localparam int OP_MULH = 13;
  localparam int OP_MULHU = 14;
  localparam int OP_DIV  = 15;
  localparam int OP_MOD  = 16;
  localparam int OP_DIVU = 17;
  localparam int OP_MODU = 18;

  localparam logic [ALU_OP_W-1:0] ALU_MUL_MASK =
    19'h07000;
  localparam logic [ALU_OP_W-1:0] ALU_DIV_MASK =
    19'h78000;

  typedef enum logic [2:0] {
    S_EMPTY,
    S_EXEC,
    S_MUL_WAIT,
    S_DIV_WAIT,
    S_HOLD,
    S_DRAIN
  } es_state_e;

endpackage

// File: rtl/exe_stage.sv
// Execute stage: latches one decoded instruction, drives the ALU,
// waits for mul/div, and hands the result to the memory stage.
// Ports: ds_* in from decode, alu_* to/from the ALU,
// es_* out to memory/forwarding, ms_allowin backpressure, es_flush.
module exe_stage
  import cpu_pkg::*;
#(
  parameter int OP_W = ALU_OP_W,
  parameter logic [OP_W-1:0] MUL_OP_MASK = ALU_MUL_MASK,
  parameter logic [OP_W-1:0] DIV_OP_MASK = ALU_DIV_MASK
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            ds_to_es_valid,
  output logic            es_allowin,
  input  logic [OP_W-1:0] ds_op,
  input  logic [31:0]     ds_src1,
  input  logic [31:0]     ds_src2,
  input  logic [4:0]      ds_dest,
  input  logic [31:0]     ds_pc,
  input  logic            es_flush,
  output logic [OP_W-1:0] alu_op,
  output logic [31:0]     alu_src1,
  output logic [31:0]     alu_src2,
  input  logic [31:0]     alu_result,
  input  logic [31:0]     mul_result,
  input  logic            alu_complete,
  output logic            es_to_ms_valid,
  input  logic            ms_allowin,
  output logic [31:0]     es_result,
  output logic [4:0]      es_dest,
  output logic [31:0]     es_pc,
  output logic [4:0]      es_fwd_dest,
  output logic            es_fwd_stall
);

  es_state_e state;
  es_state_e state_nx;
  es_state_e load_state;

  logic [OP_W-1:0] op_r;
  logic [31:0]     src1_r;
  logic [31:0]     src2_r;
  logic [31:0]     res_r;
  logic [4:0]      dest_r;
  logic [31:0]     pc_r;

  logic occupied;
  logic ready_go;
  logic accept;
  logic leave;
  logic is_mul_r;
  logic hold_load;

  assign is_mul_r = |(op_r & MUL_OP_MASK);

  assign occupied = (state == S_EXEC)
                  | (state == S_MUL_WAIT)
                  | (state == S_DIV_WAIT)
                  | (state == S_HOLD);

  always_comb begin
    ready_go = 1'b0;
    unique case (state)
      S_EXEC:     ready_go = 1'b1;
      S_HOLD:     ready_go = 1'b1;
      S_DIV_WAIT: ready_go = alu_complete;
      default:    ready_go = 1'b0;
    endcase
  end

  assign es_allowin = (state == S_EMPTY)
                    | (ready_go & ms_allowin
                       & (state != S_DRAIN));

  // Flush beats a same-cycle handshake.
  assign accept = ds_to_es_valid & es_allowin & ~es_flush;

  assign es_to_ms_valid = occupied & ready_go & ~es_flush;
  assign leave = es_to_ms_valid & ms_allowin;

  always_comb begin
    load_state = S_EXEC;
    unique case (1'b1)
      |(ds_op & DIV_OP_MASK): load_state = S_DIV_WAIT;
      |(ds_op & MUL_OP_MASK): load_state = S_MUL_WAIT;
      default:                load_state = S_EXEC;
    endcase
  end

  always_comb begin
    state_nx = state;
    if (es_flush) begin
      unique case (state)
        // The divider cannot be cancelled; keep its op
        // presented until it reports done.
        S_DIV_WAIT,
        S_DRAIN: state_nx = alu_complete ? S_EMPTY : S_DRAIN;
        default: state_nx = S_EMPTY;
      endcase
    end else begin
      unique case (state)
        S_EMPTY: begin
          if (accept) state_nx = load_state;
        end
        S_EXEC,
        S_HOLD: begin
          if (leave)
            state_nx = accept ? load_state : S_EMPTY;
          else
            state_nx = S_HOLD;
        end
        S_MUL_WAIT: state_nx = S_EXEC;
        S_DIV_WAIT: begin
          if (alu_complete) begin
            if (leave)
              state_nx = accept ? load_state : S_EMPTY;
            else
              state_nx = S_HOLD;
          end
        end
        S_DRAIN: begin
          if (alu_complete) state_nx = S_EMPTY;
        end
        default: state_nx = S_EMPTY;
      endcase
    end
  end

  // Live result source while the op is still presented.
  always_comb begin
    es_result = res_r;
    unique case (state)
      S_EXEC:
        es_result = is_mul_r ? mul_result : alu_result;
      S_DIV_WAIT: es_result = alu_result;
      default:    es_result = res_r;
    endcase
  end

  assign hold_load = (state_nx == S_HOLD)
                   & (state != S_HOLD);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= S_EMPTY;
      op_r   <= '0;
      src1_r <= '0;
      src2_r <= '0;
      res_r  <= '0;
      dest_r <= '0;
      pc_r   <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_r   <= ds_op;
        src1_r <= ds_src1;
        src2_r <= ds_src2;
        dest_r <= ds_dest;
        pc_r   <= ds_pc;
      end
      if (hold_load) res_r <= es_result;
    end
  end

  // HOLD drops the op so a finished divide is not restarted.
  assign alu_op = ((state == S_EXEC)
                 | (state == S_MUL_WAIT)
                 | (state == S_DIV_WAIT)
                 | (state == S_DRAIN)) ? op_r : '0;

  assign alu_src1 = src1_r;
  assign alu_src2 = src2_r;
  assign es_dest  = dest_r;
  assign es_pc    = pc_r;

  assign es_fwd_dest  = occupied ? dest_r : 5'd0;
  assign es_fwd_stall = (state == S_MUL_WAIT)
                      | ((state == S_DIV_WAIT) & ~alu_complete);

endmodule

// File: tb/tb_exe_stage.sv
// Testbench for exe_stage: ALU/mul/div stand-ins, directed cases,
// then random traffic checked by an in-order scoreboard.
module tb_exe_stage;
  import cpu_pkg::*;

  localparam int W = ALU_OP_W;

  logic          clk = 1'b0;
  logic          resetn;
  logic          ds_to_es_valid;
  logic          es_allowin;
  logic [W-1:0]  ds_op;
  logic [31:0]   ds_src1, ds_src2, ds_pc;
  logic [4:0]    ds_dest;
  logic          es_flush;
  logic [W-1:0]  alu_op;
  logic [31:0]   alu_src1, alu_src2;
  logic [31:0]   alu_result, mul_result;
  logic          alu_complete;
  logic          es_to_ms_valid;
  logic          ms_allowin;
  logic [31:0]   es_result, es_pc;
  logic [4:0]    es_dest, es_fwd_dest;
  logic          es_fwd_stall;

  exe_stage dut (
    .clk(clk), .resetn(resetn),
    .ds_to_es_valid(ds_to_es_valid), .es_allowin(es_allowin),
    .ds_op(ds_op), .ds_src1(ds_src1), .ds_src2(ds_src2),
    .ds_dest(ds_dest), .ds_pc(ds_pc), .es_flush(es_flush),
    .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_result(alu_result), .mul_result(mul_result),
    .alu_complete(alu_complete),
    .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
    .es_result(es_result), .es_dest(es_dest), .es_pc(es_pc),
    .es_fwd_dest(es_fwd_dest), .es_fwd_stall(es_fwd_stall)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int xfers = 0;
  int div_lat = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  dest;
    logic [31:0] pc;
  } exp_t;
  exp_t q[$];

  function automatic int op_index(logic [W-1:0] op);
    int r;
    r = -1;
    for (int i = 0; i < W; i++)
      if (op[i]) r = i;
    return r;
  endfunction

  function automatic logic [31:0] ref_alu(
    int idx, logic [31:0] a, logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = $signed(a);
    ib = $signed(b);
    case (idx)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLT:  return (ia < ib) ? 32'd1 : 32'd0;
      OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      OP_AND:  return a & b;
      OP_NOR:  return ~(a | b);
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      OP_SRA:  return $signed(a) >>> b[4:0];
      OP_LUI:  return b;
      OP_MUL:  return a * b;
      OP_MULH: begin p = sa * sb; return p[63:32]; end
      OP_MULHU: begin p = ua * ub; return p[63:32]; end
      OP_DIV:  return ia / ib;
      OP_MOD:  return ia % ib;
      OP_DIVU: return a / b;
      OP_MODU: return a % b;
      default: return 32'd0;
    endcase
  endfunction

  // ALU stand-in: the wrong-timing paths return junk so a stage
  // that picks the wrong source or moment is caught.
  logic       mul_on, div_on;
  logic [4:0] div_cnt = '0;
  assign mul_on = |(alu_op & ALU_MUL_MASK);
  assign div_on = |(alu_op & ALU_DIV_MASK);
  assign alu_complete = div_on && (int'(div_cnt) >= div_lat);

  always_comb begin
    alu_result = 32'd0;
    if (mul_on)
      alu_result = 32'hBADC0DE0;
    else if (div_on)
      alu_result = alu_complete ?
        ref_alu(op_index(alu_op), alu_src1, alu_src2) :
        32'hDEADBEEF;
    else
      alu_result = ref_alu(op_index(alu_op), alu_src1, alu_src2);
  end

  always @(posedge clk) begin
    if (div_on) div_cnt <= alu_complete ? 5'd0 : div_cnt + 5'd1;
    else        div_cnt <= 5'd0;
    mul_result <= mul_on ?
      ref_alu(op_index(alu_op), alu_src1, alu_src2) :
      32'hC0FFEE00;
  end

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Scoreboard producer: expected value computed at acceptance.
  always @(negedge clk) begin
    if (resetn) begin
      if (es_flush && q.size() > 0 && !es_to_ms_valid)
        void'(q.pop_front());
      if (ds_to_es_valid && es_allowin && !es_flush) begin
        exp_t e;
        e.res  = ref_alu(op_index(ds_op), ds_src1, ds_src2);
        e.dest = ds_dest;
        e.pc   = ds_pc;
        q.push_back(e);
      end
    end
  end

  // Scoreboard consumer: every transfer to the memory stage.
  always @(negedge clk) begin
    if (resetn && es_to_ms_valid && ms_allowin) begin
      xfers++;
      if (q.size() == 0) begin
        chk("unexpected_xfer", es_pc, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("xfer_result", es_result, e.res);
        chk("xfer_dest", {27'd0, es_dest}, {27'd0, e.dest});
        chk("xfer_pc", es_pc, e.pc);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(int idx, logic [31:0] a, logic [31:0] b,
                       logic [4:0] d, logic [31:0] p);
    logic [W-1:0] oh;
    bit ok;
    oh = '0;
    oh[idx] = 1'b1;
    ds_op = oh;
    ds_src1 = a;
    ds_src2 = b;
    ds_dest = d;
    ds_pc = p;
    ds_to_es_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = es_allowin && !es_flush;
      next_cycle();
    end
    ds_to_es_valid = 1'b0;
    if (!ok) chk("issue_timeout", 32'd0, 32'd1);
  endtask

  int xb;
  bit acc;
  int idx;
  logic [31:0] ra, rb;

  initial begin
    resetn = 1'b0;
    ds_to_es_valid = 1'b0;
    ds_op = '0;
    ds_src1 = '0;
    ds_src2 = '0;
    ds_dest = '0;
    ds_pc = '0;
    es_flush = 1'b0;
    ms_allowin = 1'b1;
    #2;
    chk("rst_allowin", {31'd0, es_allowin}, 32'd1);
    chk("rst_valid", {31'd0, es_to_ms_valid}, 32'd0);
    chk("rst_alu_op", {13'd0, alu_op}, 32'd0);
    chk("rst_result", es_result, 32'd0);
    chk("rst_dest", {27'd0, es_dest}, 32'd0);
    chk("rst_pc", es_pc, 32'd0);
    chk("rst_fwd_dest", {27'd0, es_fwd_dest}, 32'd0);
    repeat (2) next_cycle();
    resetn = 1'b1;
    next_cycle();

    // add 5+7
    issue(OP_ADD, 32'd5, 32'd7, 5'd3, 32'h1000);
    @(negedge clk);
    chk("add_valid", {31'd0, es_to_ms_valid}, 32'd1);
    chk("add_result", es_result, 32'd12);
    chk("add_allowin", {31'd0, es_allowin}, 32'd1);
    chk("add_fwd_dest", {27'd0, es_fwd_dest}, 32'd3);
    next_cycle();

    // mul.w 0xFFFFFFFF * 3
    issue(OP_MUL, 32'hFFFF_FFFF, 32'd3, 5'd4, 32'h1004);
    @(negedge clk);
    chk("mul_c0_valid", {31'd0, es_to_ms_valid}, 32'd0);
    chk("mul_c0_stall", {31'd0, es_fwd_stall}, 32'd1);
    next_cycle();
    @(negedge clk);
    chk("mul_c1_valid", {31'd0, es_to_ms_valid}, 32'd1);
    chk("mul_c1_result", es_result, 32'hFFFF_FFFD);
    chk("mul_c1_stall", {31'd0, es_fwd_stall}, 32'd0);
    next_cycle();

    // div.w -7/2, done at cycle 10
    div_lat = 10;
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'h1008);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("div_stall", {31'd0, es_fwd_stall}, 32'd1);
      chk("div_wait_valid", {31'd0, es_to_ms_valid}, 32'd0);
      next_cycle();
    end
    @(negedge clk);
    chk("div_valid", {31'd0, es_to_ms_valid}, 32'd1);
    chk("div_result", es_result, 32'hFFFF_FFFD);
    next_cycle();

    // backpressure after an add
    ms_allowin = 1'b0;
    issue(OP_ADD, 32'd100, 32'd23, 5'd6, 32'h100C);
    @(negedge clk);
    chk("hold_c0_valid", {31'd0, es_to_ms_valid}, 32'd1);
    next_cycle();
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("hold_result", es_result, 32'd123);
      chk("hold_alu_op", {13'd0, alu_op}, 32'd0);
      chk("hold_allowin", {31'd0, es_allowin}, 32'd0);
      chk("hold_valid", {31'd0, es_to_ms_valid}, 32'd1);
      next_cycle();
    end
    xb = xfers;
    ms_allowin = 1'b1;
    @(negedge clk);
    chk("release_allowin", {31'd0, es_allowin}, 32'd1);
    next_cycle();
    @(negedge clk);
    chk("release_after_valid", {31'd0, es_to_ms_valid}, 32'd0);
    chk("release_xfers", xfers - xb, 32'd1);
    next_cycle();

    // flush during a divide
    div_lat = 10;
    xb = xfers;
    issue(OP_DIV, 32'd100, 32'd7, 5'd7, 32'h1010);
    repeat (4) next_cycle();
    es_flush = 1'b1;
    @(negedge clk);
    chk("flush_c4_valid", {31'd0, es_to_ms_valid}, 32'd0);
    next_cycle();
    es_flush = 1'b0;
    for (int k = 5; k <= 10; k++) begin
      @(negedge clk);
      chk("drain_allowin", {31'd0, es_allowin}, 32'd0);
      chk("drain_valid", {31'd0, es_to_ms_valid}, 32'd0);
      next_cycle();
    end
    ms_allowin = 1'b0;
    @(negedge clk);
    chk("drain_empty_allowin", {31'd0, es_allowin}, 32'd1);
    chk("drain_empty_fwd", {27'd0, es_fwd_dest}, 32'd0);
    chk("drain_xfers", xfers - xb, 32'd0);
    next_cycle();
    ms_allowin = 1'b1;

    // flush and handshake together: nothing enters
    ds_op = '0;
    ds_op[OP_ADD] = 1'b1;
    ds_dest = 5'd9;
    ds_to_es_valid = 1'b1;
    es_flush = 1'b1;
    next_cycle();
    ds_to_es_valid = 1'b0;
    es_flush = 1'b0;
    @(negedge clk);
    chk("flush_acc_fwd", {27'd0, es_fwd_dest}, 32'd0);
    chk("flush_acc_valid", {31'd0, es_to_ms_valid}, 32'd0);
    next_cycle();

    // asynchronous reset mid-multiply
    issue(OP_MUL, 32'd6, 32'd7, 5'd10, 32'h1014);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_alu_op", {13'd0, alu_op}, 32'd0);
    chk("arst_valid", {31'd0, es_to_ms_valid}, 32'd0);
    chk("arst_allowin", {31'd0, es_allowin}, 32'd1);
    chk("arst_stall", {31'd0, es_fwd_stall}, 32'd0);
    q.delete();
    next_cycle();
    resetn = 1'b1;
    next_cycle();

    // random traffic
    acc = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!ds_to_es_valid || acc) begin
        idx = int'($urandom_range(0, W - 1));
        ra = $urandom;
        rb = $urandom;
        if ($urandom % 4 == 0) rb = rb % 33;
        if (idx >= OP_DIV) begin
          if (rb == 32'd0) rb = 32'd1;
          if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF)
            rb = 32'd3;
        end
        ds_op = '0;
        ds_op[idx] = 1'b1;
        ds_src1 = ra;
        ds_src2 = rb;
        ds_dest = 5'($urandom);
        ds_pc = $urandom;
        ds_to_es_valid = ($urandom % 3) != 0;
      end
      ms_allowin = ($urandom % 4) != 0;
      es_flush = ($urandom % 20) == 0;
      div_lat = int'($urandom_range(0, 5));
      @(negedge clk);
      acc = ds_to_es_valid && es_allowin && !es_flush;
      next_cycle();
    end
    ds_to_es_valid = 1'b0;
    es_flush = 1'b0;
    ms_allowin = 1'b1;
    for (int k = 0; k < 40 && q.size() != 0; k++)
      next_cycle();
    @(negedge clk);
    chk("final_drain", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 SHALL have parameter OP_W, default 19, giving the width of the ALU one-hot operation vector.
REQ-002 SHALL have parameter MUL_OP_MASK, default 19'h07000, marking the multiply bits (12-14).
REQ-003 SHALL have parameter DIV_OP_MASK, default 19'h78000, marking the divide/modulo bits (15-18).
REQ-004 SHALL have ports, in this order:
- clk  in  1  single clock; every register updates on its rising edge
- resetn  in  1  reset, asynchronous, active-low
- ds_to_es_valid  in  1  decode stage offers an instruction
- es_allowin  out  1  this stage accepts an instruction this cycle
- ds_op  in  OP_W  one-hot ALU operation
- ds_src1  in  32  first operand
- ds_src2  in  32  second operand
- ds_dest  in  5  destination register; 0 means no write
- ds_pc  in  32  instruction PC
- es_flush  in  1  discard the occupying instruction
- alu_op  out  OP_W  registered operation to the ALU
- alu_src1  out  32  registered operand to the ALU
- alu_src2  out  32  registered operand to the ALU
- alu_result  in  32  combinational ALU result
- mul_result  in  32  multiply result, valid one cycle after the multiply op is presented
- alu_complete  in  1  one-cycle divide-done pulse
- es_to_ms_valid  out  1  result offered downstream
- ms_allowin  in  1  memory stage accepts
- es_result  out  32  result to the memory stage
- es_dest  out  5  destination
- es_pc  out  32  PC
- es_fwd_dest  out  5  forwarding tag; 0 when the stage is empty
- es_fwd_stall  out  1  es_result is not yet valid for forwarding

Function
REQ-005 SHALL implement states EMPTY, EXEC, MUL_WAIT, DIV_WAIT, HOLD and DRAIN.
REQ-006 SHALL accept an instruction when ds_to_es_valid and es_allowin are both high.
REQ-007 SHALL drive es_allowin = (state==EMPTY) | (ready_go & ms_allowin) & ~DRAIN.
REQ-008 SHALL register op, src1, src2, dest and pc on acceptance and hold them unchanged until the instruction leaves.
REQ-009 SHALL enter EXEC on acceptance of an op outside both masks; ready_go is 1 and es_result = alu_result.
REQ-010 SHALL enter MUL_WAIT on acceptance of a multiply op; ready_go is 0 in the first occupancy cycle; in the second cycle the stage captures mul_result, then ready_go=1.
REQ-011 SHALL enter DIV_WAIT on acceptance of a divide op; the stage waits for alu_complete, then captures alu_result in the complete cycle and sets ready_go=1.
REQ-012 SHALL move a ready instruction to HOLD when ms_allowin is 0; es_result stays stable; alu_op drives 0 so no divide is re-issued.
REQ-013 SHALL drive es_to_ms_valid = occupied & ready_go & ~es_flush.
REQ-014 SHALL, on the leave edge, load a simultaneously accepted instruction back-to-back with no bubble.
REQ-015 SHALL, on es_flush outside DIV_WAIT, go to EMPTY next cycle; es_to_ms_valid stays 0.
REQ-016 SHALL, on es_flush in DIV_WAIT, go to DRAIN and keep alu_op held until alu_complete; the result is discarded, then the stage goes to EMPTY. es_allowin is 0 throughout DRAIN.
REQ-017 SHALL handle es_flush and acceptance in the same cycle as flush winning: no acceptance.
REQ-018 SHALL drive es_fwd_stall = 1 in MUL_WAIT, and in DIV_WAIT before complete.

Reset
REQ-019 SHALL, while resetn is low, asynchronously force state=EMPTY and clear every output register: es_to_ms_valid=0, alu_op=0, es_result=0, es_dest=0, es_pc=0; es_allowin then reads 1.
REQ-020 SHALL treat reset mid-divide as abandoning the divide; the divider is assumed to be reset by the same signal.

Structure
REQ-021 SHALL put the state encoding, the op bit indices and the mask constants in a shared package cpu_pkg.
REQ-022 SHALL use no sub-module; the ALU is instantiated by the parent.

Verification
REQ-023 SHALL cover add 5+7: accepted at cycle 0, ms_allowin=1 -> es_to_ms_valid at cycle 0, es_result=12, es_allowin=1.
REQ-024 SHALL cover mul.w 0xFFFFFFFF*3: -> es_to_ms_valid=0 in cycle 0 and 1 in cycle 1; es_result=0xFFFFFFFD.
REQ-025 SHALL cover div.w -7/2 with complete at cycle 10 -> es_result=0xFFFFFFFD at cycle 10, es_fwd_stall=1 in cycles 0-9.
REQ-026 SHALL cover ms_allowin=0 for 3 cycles after an add -> es_result stable, alu_op=0, es_allowin=0; release -> a single transfer.
REQ-027 SHALL cover es_flush at div cycle 4 with complete at cycle 10 -> es_allowin=0 in cycles 5-10, es_to_ms_valid never 1, EMPTY at cycle 11.
REQ-028 SHALL cover resetn low mid-MUL_WAIT -> es_to_ms_valid=0 and alu_op=0 immediately, without waiting for a clock edge.
